// File: rtl/nubus_host_bridge.sv
// nubus_host_bridge: host-side NuBus initiator for one expansion slot.
// Turns CPU cycles in the slot window into single slot transactions, serves the
// bridge control register and forwards the card's interrupt to the CPU.
module nubus_host_bridge #(
  parameter logic [3:0] SLOT_ID = 4'h9,
  parameter int         TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_sel,
  input  logic        cpu_ctl_sel,
  input  logic [23:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic [1:0]  cpu_ds,
  input  logic        cpu_rw_n,
  output logic [15:0] cpu_dout,
  output logic        cpu_dtack_n,
  output logic        cpu_berr_n,
  output logic        cpu_irq_n,
  output logic [31:0] slot_addr,
  output logic [15:0] slot_data_out,
  input  logic [15:0] slot_data_in,
  output logic [1:0]  slot_uds_lds,
  output logic        slot_rw_n,
  output logic        slot_select,
  input  logic        slot_ack_n,
  input  logic        slot_nmrq_n
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_ACK, RELEASE} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    bank_q, bank_d;
  logic          irq_en_q, irq_en_d;
  logic          tflag_q, tflag_d;
  logic [31:0]   slot_addr_q, slot_addr_d;
  logic [15:0]   slot_data_q, slot_data_d;
  logic [1:0]    slot_ds_q, slot_ds_d;
  logic          slot_rw_q, slot_rw_d;
  logic          slot_sel_q, slot_sel_d;
  logic [15:0]   dout_q, dout_d;
  logic          dtack_q, dtack_d;
  logic          berr_q, berr_d;
  logic          irq_q, irq_d;
  logic [15:0]   ctl_val;

  // Address bits outside the 4 MB slot window and the byte bit are not forwarded.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{cpu_addr[23:22], cpu_addr[0]};

  assign ctl_val = {tflag_q, 7'b0, irq_en_q, 5'b0, bank_q};

  // Next-state and output logic for the transaction FSM and the control register.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bank_d      = bank_q;
    irq_en_d    = irq_en_q;
    tflag_d     = tflag_q;
    slot_addr_d = slot_addr_q;
    slot_data_d = slot_data_q;
    slot_ds_d   = slot_ds_q;
    slot_rw_d   = slot_rw_q;
    slot_sel_d  = slot_sel_q;
    dout_d      = dout_q;
    dtack_d     = dtack_q;
    berr_d      = berr_q;
    irq_d       = ~(~slot_nmrq_n & irq_en_q);
    case (state_q)
      IDLE: begin
        if (cpu_req && cpu_sel) begin
          slot_addr_d = {4'hF, SLOT_ID, bank_q, cpu_addr[21:1], 1'b0};
          slot_data_d = cpu_din;
          slot_ds_d   = cpu_ds;
          slot_rw_d   = cpu_rw_n;
          slot_sel_d  = 1'b1;
          cnt_d       = '0;
          state_d     = WAIT_ACK;
        end else if (cpu_req && cpu_ctl_sel) begin
          // Writes return the pre-write register contents.
          dout_d  = ctl_val;
          dtack_d = 1'b0;
          if (!cpu_rw_n) begin
            if (cpu_ds[1] && cpu_din[15]) tflag_d = 1'b0;
            if (cpu_ds[0]) begin
              bank_d   = cpu_din[1:0];
              irq_en_d = cpu_din[7];
            end
          end
          state_d = RELEASE;
        end
      end
      WAIT_ACK: begin
        // An ack on the timeout edge still completes normally.
        if (!slot_ack_n) begin
          if (slot_rw_q) dout_d = slot_data_in;
          slot_sel_d = 1'b0;
          dtack_d    = 1'b0;
          state_d    = RELEASE;
        end else if (cnt_q == CNT_LAST) begin
          slot_sel_d = 1'b0;
          berr_d     = 1'b0;
          dout_d     = 16'hFFFF;
          tflag_d    = 1'b1;
          state_d    = RELEASE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RELEASE: begin
        // Wait for both the card and the CPU to let go before reopening.
        if (slot_ack_n && !cpu_req) begin
          dtack_d = 1'b1;
          berr_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bank_q      <= 2'b00;
      irq_en_q    <= 1'b0;
      tflag_q     <= 1'b0;
      slot_addr_q <= 32'h0;
      slot_data_q <= 16'h0;
      slot_ds_q   <= 2'b00;
      slot_rw_q   <= 1'b1;
      slot_sel_q  <= 1'b0;
      dout_q      <= 16'h0;
      dtack_q     <= 1'b1;
      berr_q      <= 1'b1;
      irq_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bank_q      <= bank_d;
      irq_en_q    <= irq_en_d;
      tflag_q     <= tflag_d;
      slot_addr_q <= slot_addr_d;
      slot_data_q <= slot_data_d;
      slot_ds_q   <= slot_ds_d;
      slot_rw_q   <= slot_rw_d;
      slot_sel_q  <= slot_sel_d;
      dout_q      <= dout_d;
      dtack_q     <= dtack_d;
      berr_q      <= berr_d;
      irq_q       <= irq_d;
    end
  end

  assign cpu_dout      = dout_q;
  assign cpu_dtack_n   = dtack_q;
  assign cpu_berr_n    = berr_q;
  assign cpu_irq_n     = irq_q;
  assign slot_addr     = slot_addr_q;
  assign slot_data_out = slot_data_q;
  assign slot_uds_lds  = slot_ds_q;
  assign slot_rw_n     = slot_rw_q;
  assign slot_select   = slot_sel_q;

endmodule

// File: tb/tb_nubus_host_bridge.sv
// Bench for nubus_host_bridge: every cycle all outputs are compared against
// expectations derived from the bridge's transaction rules, plus literal checks.
module tb_nubus_host_bridge;
  localparam int TMO = 16;

  logic        clk = 1'b0;
  logic        reset, cpu_req, cpu_sel, cpu_ctl_sel, cpu_rw_n;
  logic [23:0] cpu_addr;
  logic [15:0] cpu_din, cpu_dout, slot_data_out, slot_data_in;
  logic [1:0]  cpu_ds, slot_uds_lds;
  logic        cpu_dtack_n, cpu_berr_n, cpu_irq_n, slot_rw_n, slot_select;
  logic        slot_ack_n, slot_nmrq_n;
  logic [31:0] slot_addr;

  nubus_host_bridge #(.SLOT_ID(4'h9), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .cpu_sel(cpu_sel),
    .cpu_ctl_sel(cpu_ctl_sel), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_ds(cpu_ds), .cpu_rw_n(cpu_rw_n), .cpu_dout(cpu_dout),
    .cpu_dtack_n(cpu_dtack_n), .cpu_berr_n(cpu_berr_n), .cpu_irq_n(cpu_irq_n),
    .slot_addr(slot_addr), .slot_data_out(slot_data_out),
    .slot_data_in(slot_data_in), .slot_uds_lds(slot_uds_lds),
    .slot_rw_n(slot_rw_n), .slot_select(slot_select),
    .slot_ack_n(slot_ack_n), .slot_nmrq_n(slot_nmrq_n)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit check_en = 1'b0;

  // Expected outputs and the control-register model.
  logic [15:0] e_dout, e_sdo;
  logic        e_dtack_n, e_berr_n, e_irq_n, e_rw, e_sel;
  logic [31:0] e_addr;
  logic [1:0]  e_ds;
  logic [1:0]  m_bank;
  logic        m_irq_en, m_flag;
  logic [15:0] rv;

  function automatic logic [15:0] ctl_model();
    return {m_flag, 7'b0, m_irq_en, 5'b0, m_bank};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic set_reset_exp();
    e_dout = 16'h0; e_dtack_n = 1'b1; e_berr_n = 1'b1; e_irq_n = 1'b1;
    e_addr = 32'h0; e_sdo = 16'h0; e_ds = 2'b00; e_rw = 1'b1; e_sel = 1'b0;
    m_bank = 2'b00; m_irq_en = 1'b0; m_flag = 1'b0;
  endtask

  task automatic compare_all();
    if (check_en) begin
      chk("cpu_dout", {16'h0, cpu_dout}, {16'h0, e_dout});
      chk("cpu_dtack_n", {31'h0, cpu_dtack_n}, {31'h0, e_dtack_n});
      chk("cpu_berr_n", {31'h0, cpu_berr_n}, {31'h0, e_berr_n});
      chk("cpu_irq_n", {31'h0, cpu_irq_n}, {31'h0, e_irq_n});
      chk("slot_addr", slot_addr, e_addr);
      chk("slot_data_out", {16'h0, slot_data_out}, {16'h0, e_sdo});
      chk("slot_uds_lds", {30'h0, slot_uds_lds}, {30'h0, e_ds});
      chk("slot_rw_n", {31'h0, slot_rw_n}, {31'h0, e_rw});
      chk("slot_select", {31'h0, slot_select}, {31'h0, e_sel});
    end
  endtask

  // Compare the previous edge's expectations mid-cycle, then advance one edge.
  task automatic tick();
    logic irq_nx, rst;
    @(negedge clk);
    compare_all();
    irq_nx = ~(~slot_nmrq_n & m_irq_en);
    rst = reset;
    @(posedge clk);
    #1;
    e_irq_n = irq_nx;
    if (rst) set_reset_exp();
  endtask

  task automatic ctl_access(input logic rw, input logic [15:0] d, input logic [1:0] ds,
                            output logic [15:0] ret);
    cpu_req = 1'b1; cpu_sel = 1'b0; cpu_ctl_sel = 1'b1; cpu_rw_n = rw;
    cpu_din = d; cpu_ds = ds;
    ret = ctl_model();
    tick();
    e_dout = ret; e_dtack_n = 1'b0;
    if (!rw) begin
      if (ds[1] && d[15]) m_flag = 1'b0;
      if (ds[0]) begin m_bank = d[1:0]; m_irq_en = d[7]; end
    end
    cpu_req = 1'b0; cpu_ctl_sel = 1'b0;
    tick();
    e_dtack_n = 1'b1;
  endtask

  // Card acks after k idle waits; it keeps ack low for 'late' cycles after select
  // drops while the CPU also keeps its request up, then both release.
  task automatic slot_cycle(input logic rw, input logic [23:0] a, input logic [15:0] d,
                            input logic [1:0] ds, input int k, input logic [15:0] rd,
                            input int late, input logic both);
    cpu_req = 1'b1; cpu_sel = 1'b1; cpu_ctl_sel = both; cpu_rw_n = rw;
    cpu_addr = a; cpu_din = d; cpu_ds = ds; slot_ack_n = 1'b1;
    tick();
    e_sel = 1'b1; e_addr = {4'hF, 4'h9, m_bank, a[21:1], 1'b0};
    e_sdo = d; e_ds = ds; e_rw = rw;
    for (int i = 0; i < k; i++) tick();
    slot_ack_n = 1'b0; slot_data_in = rd;
    tick();
    e_sel = 1'b0; e_dtack_n = 1'b0;
    if (rw) e_dout = rd;
    for (int i = 0; i < late; i++) tick();
    slot_ack_n = 1'b1;
    tick();
    cpu_req = 1'b0; cpu_sel = 1'b0; cpu_ctl_sel = 1'b0;
    tick();
    e_dtack_n = 1'b1;
  endtask

  task automatic timeout_cycle(input logic [23:0] a);
    cpu_req = 1'b1; cpu_sel = 1'b1; cpu_ctl_sel = 1'b0; cpu_rw_n = 1'b1;
    cpu_addr = a; slot_ack_n = 1'b1;
    tick();
    e_sel = 1'b1; e_addr = {4'hF, 4'h9, m_bank, a[21:1], 1'b0};
    e_sdo = cpu_din; e_ds = cpu_ds; e_rw = 1'b1;
    for (int i = 0; i < TMO - 1; i++) tick();
    tick();
    e_sel = 1'b0; e_berr_n = 1'b0; e_dout = 16'hFFFF; m_flag = 1'b1;
    cpu_req = 1'b0; cpu_sel = 1'b0;
    tick();
    e_berr_n = 1'b1;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_sel = 1'b0; cpu_ctl_sel = 1'b0;
    cpu_addr = 24'h0; cpu_din = 16'h0; cpu_ds = 2'b00; cpu_rw_n = 1'b1;
    slot_data_in = 16'h0; slot_ack_n = 1'b1; slot_nmrq_n = 1'b1;
    set_reset_exp();
    tick();
    check_en = 1'b1;
    tick();
    reset = 1'b0;
    tick();

    // Test 1: bank = 3, slot read acked one cycle after select.
    ctl_access(1'b0, 16'h0003, 2'b11, rv);
    chk("t1_ctl_write_prev", {16'h0, rv}, 32'h0);
    ctl_access(1'b1, 16'h0, 2'b11, rv);
    chk("t1_ctl_read", {16'h0, cpu_dout}, 32'h0003);
    slot_cycle(1'b1, 24'h300010, 16'h0, 2'b11, 0, 16'hA55A, 0, 1'b0);
    chk("t1_slot_addr", slot_addr, 32'hF9F00010);
    chk("t1_cpu_dout", {16'h0, cpu_dout}, 32'hA55A);

    // Test 2: slot write with upper strobe only, card releases ack late.
    slot_cycle(1'b0, 24'h000020, 16'h1234, 2'b10, 1, 16'hDEAD, 2, 1'b0);
    chk("t2_slot_data", {16'h0, slot_data_out}, 32'h1234);
    chk("t2_slot_ds", {30'h0, slot_uds_lds}, 32'h2);
    chk("t2_slot_rw", {31'h0, slot_rw_n}, 32'h0);
    chk("t2_dout_kept", {16'h0, cpu_dout}, 32'hA55A);

    // Test 3: no ack -> bus error after TMO edges, sticky flag, clear by write.
    timeout_cycle(24'h000100);
    chk("t3_dout", {16'h0, cpu_dout}, 32'hFFFF);
    ctl_access(1'b1, 16'h0, 2'b11, rv);
    chk("t3_ctl_flag", {16'h0, cpu_dout}, 32'h8003);
    ctl_access(1'b0, 16'h8000, 2'b11, rv);
    ctl_access(1'b1, 16'h0, 2'b11, rv);
    chk("t3_ctl_cleared", {16'h0, cpu_dout}, 32'h0000);

    // Test 4: back-to-back cycles, card releases ack 3 cycles late; second
    // request also has the control select high and must still go to the slot.
    slot_cycle(1'b1, 24'h012344, 16'h0, 2'b01, 2, 16'h5AA5, 3, 1'b0);
    slot_cycle(1'b0, 24'h3FFFFE, 16'hBEEF, 2'b11, 0, 16'h0, 3, 1'b1);
    chk("t4_slot_addr", slot_addr, 32'hF93FFFFE);

    // Ack on the same edge as the timeout: normal completion, flag stays clear.
    slot_cycle(1'b1, 24'h000040, 16'h0, 2'b11, TMO - 1, 16'h0F0F, 0, 1'b0);
    chk("race_dout", {16'h0, cpu_dout}, 32'h0F0F);
    ctl_access(1'b1, 16'h0, 2'b11, rv);
    chk("race_ctl", {16'h0, cpu_dout}, 32'h0000);

    // Test 5: interrupt gating.
    slot_nmrq_n = 1'b0;
    tick();
    tick();
    chk("t5_irq_masked", {31'h0, cpu_irq_n}, 32'h1);
    ctl_access(1'b0, 16'h0080, 2'b01, rv);
    chk("t5_irq_on", {31'h0, cpu_irq_n}, 32'h0);
    slot_nmrq_n = 1'b1;
    tick();
    chk("t5_irq_off", {31'h0, cpu_irq_n}, 32'h1);

    // Test 6: reset while waiting for an ack.
    ctl_access(1'b0, 16'h0082, 2'b01, rv);
    cpu_req = 1'b1; cpu_sel = 1'b1; cpu_rw_n = 1'b1; cpu_addr = 24'h000200;
    slot_ack_n = 1'b1;
    tick();
    e_sel = 1'b1; e_addr = {4'hF, 4'h9, m_bank, 21'h000100, 1'b0};
    e_sdo = cpu_din; e_ds = cpu_ds; e_rw = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    chk("t6_select", {31'h0, slot_select}, 32'h0);
    chk("t6_dtack", {31'h0, cpu_dtack_n}, 32'h1);
    chk("t6_berr", {31'h0, cpu_berr_n}, 32'h1);
    reset = 1'b0; cpu_req = 1'b0; cpu_sel = 1'b0;
    tick();
    ctl_access(1'b1, 16'h0, 2'b11, rv);
    chk("t6_ctl", {16'h0, cpu_dout}, 32'h0000);

    @(negedge clk);
    compare_all();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
